capt_sched: RTL and testbench
=============================

CAPT_SCHED -- requirements
Module: capt_sched

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 65535, meaning maximum cycles in BUSY awaiting wr_done.
REQ-002 SHALL have parameter MAX_PKT_BYTES, default 1518, meaning largest legal descriptor length.
REQ-003 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous active-low reset.
REQ-005 SHALL have port enable  in  1  capture enable from control register bit 0.
REQ-006 SHALL have port err_clear  in  1  one-cycle pulse that leaves ERROR.
REQ-007 SHALL have port desc_valid  in  1  descriptor offered.
REQ-008 SHALL have port desc_ready  out  1  descriptor accepted when high with desc_valid.
REQ-009 SHALL have port desc_begin  in  32  packet start byte address.
REQ-010 SHALL have port desc_end  in  32  packet end byte address (exclusive).
REQ-011 SHALL have port seconds  in  32  live timestamp seconds.
REQ-012 SHALL have port nanoseconds  in  32  live timestamp nanoseconds.
REQ-013 SHALL have port wr_start  out  1  one-cycle start pulse to the packet writer.
REQ-014 SHALL have port pkt_begin  out  32  latched begin, stable from wr_start until wr_done.
REQ-015 SHALL have port pkt_end  out  32  latched end, same stability.
REQ-016 SHALL have port ts_seconds  out  32  seconds latched at descriptor accept.
REQ-017 SHALL have port ts_nanoseconds  out  32  nanoseconds latched at descriptor accept.
REQ-018 SHALL have port wr_done  in  1  one-cycle completion pulse from the writer.
REQ-019 SHALL have port busy  out  1  high in ISSUE or BUSY.
REQ-020 SHALL have port err  out  1  high in ERROR.
REQ-021 SHALL have port pkt_count  out  32  packets completed.
REQ-022 SHALL have port drop_count  out  32  descriptors discarded.
REQ-023 SHALL have port byte_count  out  32  bytes of completed packets.

Function
REQ-024 SHALL implement states IDLE, ISSUE, BUSY, ERROR.
REQ-025 SHALL assert desc_ready combinationally only in IDLE.
REQ-026 SHALL, in IDLE on desc_valid with enable=1 and 0 < desc_end-desc_begin <= MAX_PKT_BYTES (32-bit unsigned subtraction), latch begin/end/timestamps and go to ISSUE.
REQ-027 SHALL, in IDLE on desc_valid with enable=0 or illegal length, consume the descriptor, increment drop_count, stay IDLE.
REQ-028 SHALL assert wr_start for exactly one cycle in ISSUE, then go to BUSY; handshake latency desc accept to wr_start is 1 cycle.
REQ-029 SHALL, in BUSY on wr_done, increment pkt_count, add latched length to byte_count, return to IDLE.
REQ-030 SHALL count BUSY cycles; reaching TIMEOUT_CYCLES without wr_done SHALL move to ERROR.
REQ-031 SHALL ignore wr_done outside BUSY; wr_done coinciding with timeout SHALL count as completion.
REQ-032 SHALL, in ERROR, keep desc_ready low and return to IDLE on err_clear.
REQ-033 SHALL let deasserting enable during ISSUE/BUSY finish the current packet.
REQ-034 SHALL wrap all counters modulo 2^32 without saturation.

Reset
REQ-035 SHALL on reset low force IDLE and zero every output and counter immediately.
REQ-036 SHALL treat reset mid-packet as abandonment: no count updates, no wr_start after release until a new descriptor.

Configuration
REQ-037 SHALL, with macro CAPT_SCHED_STATS_EN defined, implement pkt_count, drop_count, byte_count as specified.
REQ-038 SHALL, without CAPT_SCHED_STATS_EN, tie the three counter outputs to zero with no counter registers; all other behaviour unchanged.

Structure
REQ-039 SHALL place the state enum and default MAX_PKT_BYTES/TIMEOUT_CYCLES constants in shared package capt_pkg.
REQ-040 SHALL place the timeout counter in sub-module capt_watchdog (clear, run, expired).

Verification
REQ-041 SHALL cover: begin=0x100,end=0x140 -> wr_start 1 cycle after accept; wr_done -> pkt_count=1, byte_count=64.
REQ-042 SHALL cover: enable=0 with valid desc -> desc_ready=1, drop_count=1, no wr_start.
REQ-043 SHALL cover: end=begin and length 1519 -> both dropped, drop_count=2.
REQ-044 SHALL cover: TIMEOUT_CYCLES=8, no wr_done -> err=1 on cycle 8 of BUSY; err_clear -> IDLE, desc_ready=1.
REQ-045 SHALL cover: reset asserted in BUSY -> all outputs 0 asynchronously; later wr_done ignored.
REQ-046 SHALL cover: back-to-back valid descriptors -> second accepted cycle after wr_done, timestamps latched per accept.

Source files
------------

// File: rtl/capt_pkg.sv
// Shared definitions for the capture scheduler: FSM state encoding, default
// limits and the descriptor length legality check.
package capt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_BUSY,
    ST_ERROR
  } capt_state_t;

  localparam int DEF_MAX_PKT_BYTES  = 1518;
  localparam int DEF_TIMEOUT_CYCLES = 65535;

  // Length is end - begin in 32-bit unsigned arithmetic, so begin > end wraps huge.
  function automatic logic desc_len_ok(input logic [31:0] b,
                                       input logic [31:0] e,
                                       input int          max_bytes);
    logic [31:0] len;
    len = e - b;
    return (len != 32'd0) && (len <= 32'(max_bytes));
  endfunction

endpackage

// File: rtl/capt_watchdog.sv
// BUSY-phase watchdog: counts cycles while run is high and flags expiry
// during the last permitted cycle so the FSM can leave on the next edge.
module capt_watchdog #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = run && (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/capt_sched.sv
// Capture scheduler: accepts packet descriptors, issues one write per packet
// and supervises completion. Statistics counters exist only with CAPT_SCHED_STATS_EN.
module capt_sched
  import capt_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int MAX_PKT_BYTES  = DEF_MAX_PKT_BYTES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        err_clear,
  input  logic        desc_valid,
  output logic        desc_ready,
  input  logic [31:0] desc_begin,
  input  logic [31:0] desc_end,
  input  logic [31:0] seconds,
  input  logic [31:0] nanoseconds,
  output logic        wr_start,
  output logic [31:0] pkt_begin,
  output logic [31:0] pkt_end,
  output logic [31:0] ts_seconds,
  output logic [31:0] ts_nanoseconds,
  input  logic        wr_done,
  output logic        busy,
  output logic        err,
  output logic [31:0] pkt_count,
  output logic [31:0] drop_count,
  output logic [31:0] byte_count
);

  capt_state_t state, state_next;
  logic        accept;
  logic        wd_run;
  logic        wd_expired;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // wr_done wins over expiry so a completion in the final allowed cycle still counts.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    wr_start   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (desc_valid && enable && desc_len_ok(desc_begin, desc_end, MAX_PKT_BYTES)) begin
          accept     = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wr_start   = 1'b1;
        state_next = ST_BUSY;
      end
      ST_BUSY: begin
        if (wr_done) begin
          state_next = ST_IDLE;
        end else if (wd_expired) begin
          state_next = ST_ERROR;
        end
      end
      ST_ERROR: begin
        if (err_clear) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Gated with reset so every output reads zero while reset is held.
  assign desc_ready = reset && (state == ST_IDLE);
  assign busy       = (state == ST_ISSUE) || (state == ST_BUSY);
  assign err        = (state == ST_ERROR);
  assign wd_run     = (state == ST_BUSY);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt_begin      <= '0;
      pkt_end        <= '0;
      ts_seconds     <= '0;
      ts_nanoseconds <= '0;
    end else if (accept) begin
      pkt_begin      <= desc_begin;
      pkt_end        <= desc_end;
      ts_seconds     <= seconds;
      ts_nanoseconds <= nanoseconds;
    end
  end

  capt_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (!wd_run),
    .run    (wd_run),
    .expired(wd_expired)
  );

`ifdef CAPT_SCHED_STATS_EN
  logic drop_desc;
  logic complete;

  assign drop_desc = (state == ST_IDLE) && desc_valid && !accept;
  assign complete  = (state == ST_BUSY) && wr_done;

  // Counters wrap naturally at 2^32.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt_count  <= '0;
      drop_count <= '0;
      byte_count <= '0;
    end else begin
      if (drop_desc) begin
        drop_count <= drop_count + 32'd1;
      end
      if (complete) begin
        pkt_count  <= pkt_count + 32'd1;
        byte_count <= byte_count + (pkt_end - pkt_begin);
      end
    end
  end
`else
  assign pkt_count  = '0;
  assign drop_count = '0;
  assign byte_count = '0;
`endif

endmodule

// File: tb/tb_capt_sched.sv
// Scoreboarded testbench for capt_sched: each accepted descriptor is queued and
// checked against the latched packet fields when wr_start appears.
module tb_capt_sched;

  localparam int TO   = 8;
  localparam int MAXB = 1518;
`ifdef CAPT_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        enable;
  logic        err_clear;
  logic        desc_valid;
  logic        desc_ready;
  logic [31:0] desc_begin;
  logic [31:0] desc_end;
  logic [31:0] seconds;
  logic [31:0] nanoseconds;
  logic        wr_start;
  logic [31:0] pkt_begin;
  logic [31:0] pkt_end;
  logic [31:0] ts_seconds;
  logic [31:0] ts_nanoseconds;
  logic        wr_done;
  logic        busy;
  logic        err;
  logic [31:0] pkt_count;
  logic [31:0] drop_count;
  logic [31:0] byte_count;

  typedef struct packed {
    logic [31:0] b;
    logic [31:0] e;
    logic [31:0] s;
    logic [31:0] ns;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_pkt;
  logic [31:0] exp_drop;
  logic [31:0] exp_bytes;

  capt_sched #(
    .TIMEOUT_CYCLES(TO),
    .MAX_PKT_BYTES (MAXB)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .err_clear     (err_clear),
    .desc_valid    (desc_valid),
    .desc_ready    (desc_ready),
    .desc_begin    (desc_begin),
    .desc_end      (desc_end),
    .seconds       (seconds),
    .nanoseconds   (nanoseconds),
    .wr_start      (wr_start),
    .pkt_begin     (pkt_begin),
    .pkt_end       (pkt_end),
    .ts_seconds    (ts_seconds),
    .ts_nanoseconds(ts_nanoseconds),
    .wr_done       (wr_done),
    .busy          (busy),
    .err           (err),
    .pkt_count     (pkt_count),
    .drop_count    (drop_count),
    .byte_count    (byte_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  function automatic logic [31:0] expCnt(input logic [31:0] v);
    return STATS ? v : 32'd0;
  endfunction

  task automatic checkCounters(input string tag);
    checkOutput({tag, "_pkt_count"},  pkt_count,  expCnt(exp_pkt));
    checkOutput({tag, "_drop_count"}, drop_count, expCnt(exp_drop));
    checkOutput({tag, "_byte_count"}, byte_count, expCnt(exp_bytes));
  endtask

  // Offers one descriptor for a single cycle; returns at the negedge after the accept edge.
  task automatic applyStimulus(input logic [31:0] b, input logic [31:0] e,
                               input logic [31:0] s, input logic [31:0] ns,
                               input bit accept);
    @(negedge clk);
    checkOutput("desc_ready_idle", desc_ready, 32'd1);
    if (accept) exp_q.push_back('{b: b, e: e, s: s, ns: ns});
    desc_begin  = b;
    desc_end    = e;
    seconds     = s;
    nanoseconds = ns;
    desc_valid  = 1'b1;
    @(negedge clk);
    desc_valid  = 1'b0;
    seconds     = ~s;
    nanoseconds = ~ns;
    if (accept) begin
      checkOutput("accept_latency_wr_start", wr_start, 32'd1);
    end else begin
      checkOutput("drop_no_wr_start", wr_start, 32'd0);
      checkOutput("drop_stays_idle", desc_ready, 32'd1);
    end
  endtask

  // Completes the packet in BUSY: called at the ISSUE negedge.
  task automatic finishPacket();
    @(negedge clk);
    wr_done = 1'b1;
    @(negedge clk);
    wr_done = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every wr_start and checks the latched fields.
  initial begin : monitor
    logic last_start;
    exp_t e;
    last_start = 1'b0;
    forever begin
      @(negedge clk);
      if (wr_start) begin
        checkOutput("wr_start_single_cycle", {31'd0, last_start}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_wr_start: got wr_start=1, expected no pending descriptor");
        end else begin
          e = exp_q.pop_front();
          checkOutput("pkt_begin",      pkt_begin,      e.b);
          checkOutput("pkt_end",        pkt_end,        e.e);
          checkOutput("ts_seconds",     ts_seconds,     e.s);
          checkOutput("ts_nanoseconds", ts_nanoseconds, e.ns);
        end
      end
      last_start = wr_start;
    end
  end

  initial begin : guard
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] time limit reached");
  end

  initial begin : stimulus
    reset       = 1'b0;
    enable      = 1'b0;
    err_clear   = 1'b0;
    desc_valid  = 1'b0;
    desc_begin  = '0;
    desc_end    = '0;
    seconds     = '0;
    nanoseconds = '0;
    wr_done     = 1'b0;
    exp_pkt     = '0;
    exp_drop    = '0;
    exp_bytes   = '0;

    repeat (2) @(negedge clk);
    checkOutput("rst_desc_ready", desc_ready, 32'd0);
    checkOutput("rst_busy",       busy,       32'd0);
    checkOutput("rst_err",        err,        32'd0);
    checkOutput("rst_wr_start",   wr_start,   32'd0);
    checkCounters("rst");
    reset  = 1'b1;
    enable = 1'b1;

    // Basic packet 0x100..0x140 (64 bytes)
    applyStimulus(32'h100, 32'h140, 32'd11, 32'd22, 1'b1);
    @(negedge clk);
    checkOutput("busy_in_busy",      busy,       32'd1);
    checkOutput("ready_low_busy",    desc_ready, 32'd0);
    checkOutput("ts_held_after_acc", ts_seconds, 32'd11);
    wr_done = 1'b1;
    @(negedge clk);
    wr_done = 1'b0;
    exp_pkt = 1; exp_bytes = 64;
    checkOutput("idle_after_done", busy, 32'd0);
    checkCounters("pkt1");

    // wr_done in IDLE is ignored
    wr_done = 1'b1;
    @(negedge clk);
    wr_done = 1'b0;
    checkCounters("stray_done");

    // Disabled capture drops a legal descriptor
    enable = 1'b0;
    applyStimulus(32'h200, 32'h240, 32'd1, 32'd2, 1'b0);
    exp_drop = 1;
    checkCounters("disabled_drop");
    enable = 1'b1;

    // Illegal lengths: zero, MAX+1, negative
    applyStimulus(32'h300, 32'h300, 32'd3, 32'd4, 1'b0);
    applyStimulus(32'h1000, 32'h1000 + 32'd1519, 32'd5, 32'd6, 1'b0);
    applyStimulus(32'h50, 32'h10, 32'd7, 32'd8, 1'b0);
    exp_drop = 4;
    checkCounters("illegal_len");

    // Exactly MAX_PKT_BYTES and an address-wrapping descriptor are legal
    applyStimulus(32'h1000, 32'h1000 + 32'd1518, 32'd9, 32'd10, 1'b1);
    finishPacket();
    exp_pkt = 2; exp_bytes = 64 + 1518;
    checkCounters("max_len");
    applyStimulus(32'hFFFF_FFF0, 32'h10, 32'd12, 32'd13, 1'b1);
    finishPacket();
    exp_pkt = 3; exp_bytes = 64 + 1518 + 32;
    checkCounters("wrap_addr");

    // Timeout: 8 BUSY cycles without wr_done
    applyStimulus(32'h400, 32'h410, 32'd14, 32'd15, 1'b1);
    for (int i = 0; i < TO; i++) begin
      @(negedge clk);
      checkOutput("err_before_timeout", err, 32'd0);
    end
    @(negedge clk);
    checkOutput("err_at_timeout",   err,        32'd1);
    checkOutput("busy_in_error",    busy,       32'd0);
    checkOutput("ready_in_error",   desc_ready, 32'd0);
    desc_begin = 32'h500; desc_end = 32'h510; desc_valid = 1'b1;
    @(negedge clk);
    desc_valid = 1'b0;
    checkOutput("error_holds",      err,        32'd1);
    checkCounters("error_no_drop");
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    checkOutput("err_cleared",      err,        32'd0);
    checkOutput("ready_after_clr",  desc_ready, 32'd1);

    // wr_done on the final allowed BUSY cycle counts as completion
    applyStimulus(32'h600, 32'h608, 32'd16, 32'd17, 1'b1);
    repeat (TO) @(negedge clk);
    wr_done = 1'b1;
    @(negedge clk);
    wr_done = 1'b0;
    exp_pkt = 4; exp_bytes = 64 + 1518 + 32 + 8;
    checkOutput("late_done_no_err", err,        32'd0);
    checkOutput("late_done_idle",   desc_ready, 32'd1);
    checkCounters("late_done");

    // Asynchronous reset in BUSY abandons the packet
    applyStimulus(32'h700, 32'h720, 32'd18, 32'd19, 1'b1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    exp_pkt = 0; exp_drop = 0; exp_bytes = 0;
    checkOutput("arst_busy",        busy,           32'd0);
    checkOutput("arst_err",         err,            32'd0);
    checkOutput("arst_desc_ready",  desc_ready,     32'd0);
    checkOutput("arst_wr_start",    wr_start,       32'd0);
    checkOutput("arst_pkt_begin",   pkt_begin,      32'd0);
    checkOutput("arst_pkt_end",     pkt_end,        32'd0);
    checkOutput("arst_ts_seconds",  ts_seconds,     32'd0);
    checkOutput("arst_ts_nanosec",  ts_nanoseconds, 32'd0);
    checkCounters("arst");
    @(negedge clk);
    reset   = 1'b1;
    wr_done = 1'b1;
    @(negedge clk);
    wr_done = 1'b0;
    checkOutput("post_rst_idle", desc_ready, 32'd1);
    checkCounters("post_rst_done");
    repeat (3) @(negedge clk);

    // Back-to-back descriptors with desc_valid held
    @(negedge clk);
    exp_q.push_back('{b: 32'h800, e: 32'h840, s: 32'd1000, ns: 32'd5});
    desc_begin = 32'h800; desc_end = 32'h840; seconds = 32'd1000; nanoseconds = 32'd5;
    desc_valid = 1'b1;
    @(negedge clk);
    checkOutput("b2b_first_start", wr_start, 32'd1);
    exp_q.push_back('{b: 32'h900, e: 32'h910, s: 32'd2000, ns: 32'd6});
    desc_begin = 32'h900; desc_end = 32'h910; seconds = 32'd2000; nanoseconds = 32'd6;
    @(negedge clk);
    checkOutput("b2b_busy", busy, 32'd1);
    wr_done = 1'b1;
    @(negedge clk);
    wr_done = 1'b0;
    exp_pkt = 1; exp_bytes = 64;
    checkOutput("b2b_ready_again", desc_ready, 32'd1);
    checkCounters("b2b_first");
    @(negedge clk);
    desc_valid = 1'b0;
    seconds    = 32'hDEAD;
    checkOutput("b2b_second_start", wr_start, 32'd1);
    finishPacket();
    exp_pkt = 2; exp_bytes = 80;
    checkCounters("b2b_second");
    repeat (2) @(negedge clk);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
